// File: rtl/prv32_alu_issue.sv
// ID->EX issue stage: decodes RV32I ALU-class instructions into ALU operands/function code
// and registers them through a main entry plus a one-entry skid buffer.
module prv32_alu_issue #(
    parameter int unsigned XLEN           = 32,
    parameter bit          ILLEGAL_AS_NOP = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [4:0]      alu_shamt,
    output logic [3:0]      alu_fn,
    output logic [4:0]      rd,
    output logic            rd_we,
    output logic            illegal
);

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      shamt;
        logic [3:0]      fn;
        logic [4:0]      rd;
        logic            rd_we;
        logic            illegal;
    } entry_t;

    localparam logic [6:0] OpcOp    = 7'b0110011;
    localparam logic [6:0] OpcOpImm = 7'b0010011;
    localparam logic [6:0] OpcLui   = 7'b0110111;
    localparam logic [6:0] OpcAuipc = 7'b0010111;

    entry_t     w_dec;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_alt;
    logic [3:0] w_fn;
    logic       w_accept;
    logic       w_keep;
    logic       w_emit;

    entry_t     r_main;
    entry_t     r_skid;
    logic       r_main_valid;
    logic       r_skid_valid;

    assign w_f3 = inst[14:12];
    assign w_f7 = inst[31:25];

    // inst[30] selects SUB/SRA; for ADDI it is just an immediate bit.
    always_comb begin
        w_alt = inst[30] && !((inst[6:0] == OpcOpImm) && (w_f3 == 3'b000));
        unique case (w_f3)
            3'b000:  w_fn = w_alt ? 4'b0001 : 4'b0000;
            3'b001:  w_fn = 4'b1001;
            3'b010:  w_fn = 4'b1101;
            3'b011:  w_fn = 4'b1111;
            3'b100:  w_fn = 4'b0111;
            3'b101:  w_fn = w_alt ? 4'b1010 : 4'b1000;
            3'b110:  w_fn = 4'b0100;
            default: w_fn = 4'b0101;
        endcase
    end

    always_comb begin
        w_dec         = '0;
        w_dec.rd      = inst[11:7];
        w_dec.illegal = 1'b0;
        case (inst[6:0])
            OpcOp: begin
                w_dec.a       = rs1_data;
                w_dec.b       = rs2_data;
                w_dec.shamt   = rs2_data[4:0];
                w_dec.fn      = w_fn;
                w_dec.illegal = !((w_f7 == 7'h00) ||
                                  ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
            end
            OpcOpImm: begin
                w_dec.a       = rs1_data;
                w_dec.b       = {{(XLEN-12){inst[31]}}, inst[31:20]};
                w_dec.shamt   = inst[24:20];
                w_dec.fn      = w_fn;
                w_dec.illegal = ((w_f3 == 3'b001) && (w_f7 != 7'h00)) ||
                                ((w_f3 == 3'b101) && (w_f7 != 7'h00) && (w_f7 != 7'h20));
            end
            OpcLui: begin
                w_dec.b  = {inst[31:12], 12'b0};
                w_dec.fn = 4'b0011;
            end
            OpcAuipc: begin
                w_dec.a  = pc;
                w_dec.b  = {inst[31:12], 12'b0};
                w_dec.fn = 4'b0000;
            end
            default: w_dec.illegal = 1'b1;
        endcase
        if (w_dec.illegal) begin
            w_dec.a     = '0;
            w_dec.b     = '0;
            w_dec.shamt = '0;
            w_dec.fn    = '0;
            w_dec.rd_we = 1'b0;
        end else begin
            w_dec.rd_we = (inst[11:7] != 5'd0);
        end
    end

    assign in_ready = !r_skid_valid;
    assign w_accept = in_valid && in_ready && !flush;
    assign w_keep   = w_accept && (ILLEGAL_AS_NOP || !w_dec.illegal);
    assign w_emit   = r_main_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || w_emit) begin
            // A full skid blocks in_ready, so no new entry competes with it here.
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_keep;
                if (w_keep) begin
                    r_main <= w_dec;
                end
            end
        end else if (w_keep) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end

    assign out_valid = r_main_valid;
    assign alu_a     = r_main.a;
    assign alu_b     = r_main.b;
    assign alu_shamt = r_main.shamt;
    assign alu_fn    = r_main.fn;
    assign rd        = r_main.rd;
    assign rd_we     = r_main.rd_we;
    assign illegal   = r_main.illegal;

endmodule

// File: tb/tb_prv32_alu_issue.sv
// Directed bench for prv32_alu_issue: decode table plus back-pressure, flush and async reset.
module tb_prv32_alu_issue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_fn;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;

    int n_checks = 0;
    int n_errors = 0;

    prv32_alu_issue #(
        .XLEN(32),
        .ILLEGAL_AS_NOP(1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .inst     (inst),
        .pc       (pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_shamt(alu_shamt),
        .alu_fn   (alu_fn),
        .rd       (rd),
        .rd_we    (rd_we),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic [3:0]  fn;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_entry(input string tag, input vec_t v);
        check({tag, " out_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, " a"}, alu_a, v.a);
        check({tag, " b"}, alu_b, v.b);
        check({tag, " shamt"}, {27'b0, alu_shamt}, {27'b0, v.shamt});
        check({tag, " fn"}, {28'b0, alu_fn}, {28'b0, v.fn});
        check({tag, " rd"}, {27'b0, rd}, {27'b0, v.rd});
        check({tag, " rd_we"}, {31'b0, rd_we}, {31'b0, v.we});
        check({tag, " illegal"}, {31'b0, illegal}, {31'b0, v.ill});
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " out_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
        check({tag, " a"}, alu_a, 32'd0);
        check({tag, " b"}, alu_b, 32'd0);
        check({tag, " shamt/fn/rd"}, {19'b0, alu_shamt, alu_fn, rd}, 32'd0);
        check({tag, " rd_we/illegal"}, {30'b0, rd_we, illegal}, 32'd0);
    endtask

    function automatic logic [31:0] mk_add(input logic [4:0] dst);
        return {7'h00, 5'd2, 5'd1, 3'b000, dst, 7'h33};
    endfunction

    task automatic drive(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
        in_valid = 1'b1;
        inst     = i;
        rs1_data = r1;
        rs2_data = r2;
    endtask

    initial begin
        vec_t e;

        //          inst          pc           rs1          rs2   a            b            sh   fn       rd  we  ill
        vecs.push_back('{32'h002081B3, 32'h0, 32'd5, 32'd7, 32'd5, 32'd7, 5'd7, 4'b0000, 5'd3, 1'b1, 1'b0});
        vecs.push_back('{32'h402081B3, 32'h0, 32'd5, 32'd7, 32'd5, 32'd7, 5'd7, 4'b0001, 5'd3, 1'b1, 1'b0});
        vecs.push_back('{32'h40435293, 32'h0, 32'h80000000, 32'd0, 32'h80000000, 32'h404, 5'd4,
                         4'b1010, 5'd5, 1'b1, 1'b0});
        vecs.push_back('{32'h123450B7, 32'h0, 32'd9, 32'd9, 32'd0, 32'h12345000, 5'd0, 4'b0011,
                         5'd1, 1'b1, 1'b0});
        vecs.push_back('{32'h00001397, 32'h100, 32'd9, 32'd9, 32'h100, 32'h1000, 5'd0, 4'b0000,
                         5'd7, 1'b1, 1'b0});
        vecs.push_back('{32'hFFF00093, 32'h0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 5'd31, 4'b0000,
                         5'd1, 1'b1, 1'b0});
        vecs.push_back('{32'h40008093, 32'h0, 32'd1, 32'd0, 32'd1, 32'h400, 5'd0, 4'b0000, 5'd1,
                         1'b1, 1'b0});
        vecs.push_back('{32'h00309093, 32'h0, 32'h10, 32'd0, 32'h10, 32'd3, 5'd3, 4'b1001, 5'd1,
                         1'b1, 1'b0});
        vecs.push_back('{32'h00209233, 32'h0, 32'd3, 32'd9, 32'd3, 32'd9, 5'd9, 4'b1001, 5'd4, 1'b1, 1'b0});
        vecs.push_back('{32'h0020A233, 32'h0, 32'd3, 32'd9, 32'd3, 32'd9, 5'd9, 4'b1101, 5'd4, 1'b1, 1'b0});
        vecs.push_back('{32'h0020B233, 32'h0, 32'd3, 32'd9, 32'd3, 32'd9, 5'd9, 4'b1111, 5'd4, 1'b1, 1'b0});
        vecs.push_back('{32'h0020C233, 32'h0, 32'd3, 32'd9, 32'd3, 32'd9, 5'd9, 4'b0111, 5'd4, 1'b1, 1'b0});
        vecs.push_back('{32'h0020D233, 32'h0, 32'd3, 32'd9, 32'd3, 32'd9, 5'd9, 4'b1000, 5'd4, 1'b1, 1'b0});
        vecs.push_back('{32'h4020D233, 32'h0, 32'd3, 32'd9, 32'd3, 32'd9, 5'd9, 4'b1010, 5'd4, 1'b1, 1'b0});
        vecs.push_back('{32'h0020E233, 32'h0, 32'd3, 32'd9, 32'd3, 32'd9, 5'd9, 4'b0100, 5'd4, 1'b1, 1'b0});
        vecs.push_back('{32'h0020F233, 32'h0, 32'd3, 32'd9, 32'd3, 32'd9, 5'd9, 4'b0101, 5'd4, 1'b1, 1'b0});
        vecs.push_back('{32'h00208033, 32'h0, 32'd5, 32'd7, 32'd5, 32'd7, 5'd7, 4'b0000, 5'd0, 1'b0, 1'b0});
        vecs.push_back('{32'h0000007F, 32'h0, 32'd5, 32'd7, 32'd0, 32'd0, 5'd0, 4'b0000, 5'd0, 1'b0, 1'b1});
        vecs.push_back('{32'h7E0081B3, 32'h0, 32'd5, 32'd7, 32'd0, 32'd0, 5'd0, 4'b0000, 5'd3, 1'b0, 1'b1});
        vecs.push_back('{32'h402091B3, 32'h0, 32'd5, 32'd7, 32'd0, 32'd0, 5'd0, 4'b0000, 5'd3, 1'b0, 1'b1});
        vecs.push_back('{32'h40009093, 32'h0, 32'd5, 32'd7, 32'd0, 32'd0, 5'd0, 4'b0000, 5'd1, 1'b0, 1'b1});

        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        inst      = '0;
        pc        = '0;
        rs1_data  = '0;
        rs2_data  = '0;
        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Streamed back-to-back with out_ready high: each vector visible one edge later.
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            pc = vecs[i].pc;
            drive(vecs[i].inst, vecs[i].rs1, vecs[i].rs2);
            step();
            check_entry($sformatf("vec%0d", i), vecs[i]);
        end
        in_valid = 1'b0;
        step();
        check("drain out_valid", {31'b0, out_valid}, 32'd0);

        // Back-pressure: A fills main, B fills skid, C is held off.
        e = vecs[0];
        out_ready = 1'b0;
        drive(mk_add(5'd10), 32'd100, 32'd7);
        step();
        check("bp in_ready after A", {31'b0, in_ready}, 32'd1);
        drive(mk_add(5'd11), 32'd101, 32'd7);
        step();
        check("bp in_ready after B", {31'b0, in_ready}, 32'd0);
        drive(mk_add(5'd12), 32'd102, 32'd7);
        step();
        check("bp in_ready held", {31'b0, in_ready}, 32'd0);
        e.a = 32'd100; e.rd = 5'd10;
        check_entry("bp stall A", e);
        out_ready = 1'b1;
        step();
        e.a = 32'd101; e.rd = 5'd11;
        check_entry("bp emit B", e);
        check("bp in_ready reopen", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        e.a = 32'd102; e.rd = 5'd12;
        check_entry("bp emit C", e);
        step();
        check("bp drained", {31'b0, out_valid}, 32'd0);

        // Flush with main and skid full and a new instruction offered.
        out_ready = 1'b0;
        drive(mk_add(5'd13), 32'd200, 32'd7);
        step();
        drive(mk_add(5'd14), 32'd201, 32'd7);
        step();
        drive(mk_add(5'd15), 32'd202, 32'd7);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush out_valid", {31'b0, out_valid}, 32'd0);
        check("flush in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        step();
        check("flush no stale 1", {31'b0, out_valid}, 32'd0);
        step();
        check("flush no stale 2", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset in the middle of a stall.
        out_ready = 1'b0;
        drive(mk_add(5'd16), 32'd300, 32'd7);
        step();
        drive(mk_add(5'd17), 32'd301, 32'd7);
        step();
        in_valid = 1'b0;
        check("pre-reset out_valid", {31'b0, out_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_zero_outputs("async reset");
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(mk_add(5'd18), 32'd400, 32'd8);
        step();
        in_valid = 1'b0;
        e.a = 32'd400; e.b = 32'd8; e.shamt = 5'd8; e.rd = 5'd18;
        check_entry("post-reset add", e);
        step();
        check("post-reset drained", {31'b0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
